// File: rtl/iram_wr_arbiter_pkg.sv
// iram_arb_pkg: shared types and defaults for the IRAM write-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT, HOLD, FIN, DONE)
//   IRAM_AW/DW  : default IRAM address/data widths
//   IRAM_DEPTH  : IRAM word count
package iram_arb_pkg;

    localparam int unsigned IRAM_DEPTH = 64;
    localparam int unsigned IRAM_AW    = 6;
    localparam int unsigned IRAM_DW    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        HOLD  = 3'd2,
        FIN   = 3'd3,
        DONE  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/iram_wr_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick among NREQ requesters.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_i       : request vector
//   upd_i       : a beat was accepted this cycle
//   upd_idx_i   : index of the accepted requester
//   grant_o     : one-hot, first request at or after the pointer
// The pointer moves to winner+1 (mod NREQ) on every accept.
module rr_arbiter #(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned PW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            upd_i,
    input  logic [PW-1:0]   upd_idx_i,
    output logic [NREQ-1:0] grant_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] cand;
    logic          found;
    int unsigned   sum;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        sum     = 0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sum = 32'(ptr_q) + i;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            cand = sum[PW-1:0];
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = upd_idx_i + PW'(1);
        if (upd_idx_i == PW'(NREQ - 1)) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (upd_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/iram_wr_arbiter.sv
// iram_wr_arbiter: shares the single IRAM write port between NREQ requesters.
//   clk, rst_n           : clock (posedge), asynchronous active-low reset
//   req_valid/addr/data  : per-requester write beat, requester i packed at [i*W +: W]
//   req_last             : last beat of a burst (burst build only)
//   req_ready            : one-hot grant; beat transfers when valid & ready at posedge
//   fin_req              : finish request, level, held until done
//   iram_valid/addr/data : registered IRAM write stage (IRAM captures on negedge)
//   busy                 : GRANT/HOLD state or a staged write
//   done                 : one-cycle pulse when a finish drains
//   wr_count             : committed writes since reset, saturating
// Build option: define IRAM_ARB_BURST_EN to lock the grant to one requester
// until req_last or BURST_MAX beats (HOLD state); otherwise every beat is
// re-arbitrated and req_last is ignored.
module iram_wr_arbiter
    import iram_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned AW        = IRAM_AW,
    parameter int unsigned DW        = IRAM_DW,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    input  logic               fin_req,
    output logic               iram_valid,
    output logic [AW-1:0]      iram_addr,
    output logic [DW-1:0]      iram_data,
    output logic               busy,
    output logic               done,
    output logic [AW:0]        wr_count
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = AW + 1;

    arb_state_e     state_q, state_d;
    logic           iram_valid_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  data_q;
    logic           done_q, done_d;
    logic [CW-1:0]  wr_count_q, wr_count_d;

    logic [NREQ-1:0] arb_grant;
    logic [NREQ-1:0] ready_c;
    logic            accept;
    logic [PW-1:0]   win_idx;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            sel_last;

`ifdef IRAM_ARB_BURST_EN
    localparam int unsigned BW = $clog2(BURST_MAX + 1);
    logic [PW-1:0] holder_q, holder_d;
    logic [BW-1:0] beat_q, beat_d;
`else
    logic unused_cfg;
    assign unused_cfg = (^req_last) ^ (BURST_MAX == 0);
`endif

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid),
        .upd_i     (accept),
        .upd_idx_i (win_idx),
        .grant_o   (arb_grant)
    );

    // Ready is gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        ready_c = '0;
        if (rst_n) begin
            case (state_q)
                IDLE, GRANT, FIN: ready_c = arb_grant;
`ifdef IRAM_ARB_BURST_EN
                HOLD:             ready_c = req_valid & (NREQ'(1) << holder_q);
`endif
                default:          ready_c = '0;
            endcase
        end
    end

    assign accept = |ready_c;

    always_comb begin
        win_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (ready_c[i]) begin
                win_idx  = PW'(i);
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
                sel_last = req_last[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
`ifdef IRAM_ARB_BURST_EN
        holder_d = holder_q;
        beat_d   = beat_q;
`endif
        case (state_q)
            IDLE, GRANT: begin
                if (accept) begin
                    state_d = GRANT;
`ifdef IRAM_ARB_BURST_EN
                    if (!sel_last && BURST_MAX > 1) begin
                        state_d  = HOLD;
                        holder_d = win_idx;
                        beat_d   = BW'(1);
                    end
`endif
                end else if (fin_req) begin
                    state_d = FIN;
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef IRAM_ARB_BURST_EN
            HOLD: begin
                if (accept) begin
                    if (sel_last || (32'(beat_q) + 1 >= BURST_MAX)) begin
                        state_d = GRANT;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
`endif
            // Requests arriving during FIN are served per beat without a burst
            // lock; completion waits until nothing is accepted and the stage is empty.
            FIN: begin
                if (!accept && !iram_valid_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                if (!fin_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (iram_valid_q && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            iram_valid_q <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            done_q       <= 1'b0;
            wr_count_q   <= '0;
`ifdef IRAM_ARB_BURST_EN
            holder_q     <= '0;
            beat_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            iram_valid_q <= accept;
            wr_count_q   <= wr_count_d;
            if (accept) begin
                addr_q <= sel_addr;
                data_q <= sel_data;
            end
`ifdef IRAM_ARB_BURST_EN
            holder_q     <= holder_d;
            beat_q       <= beat_d;
`endif
        end
    end

    assign req_ready  = ready_c;
    assign iram_valid = iram_valid_q;
    assign iram_addr  = addr_q;
    assign iram_data  = data_q;
    assign done       = done_q;
    assign wr_count   = wr_count_q;
    assign busy       = (state_q == GRANT) || (state_q == HOLD) || iram_valid_q;

endmodule
